cordic_arbiter: RTL and testbench

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

---
 rtl/cordic_pkg.sv | 15 +
 rtl/cordic_rr_arb2.sv | 16 +
 rtl/cordic_arbiter.sv | 129 ++++++++++++
 tb/tb_cordic_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared types and defaults for the cordic arbiter
package cordic_pkg;

  localparam int CORDIC_DW       = 16;
  localparam int CORDIC_LATENCY  = 16;
  // operands and results are sign-magnitude: the top bit carries the sign
  localparam int CORDIC_SIGN_BIT = CORDIC_DW - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } cordic_state_e;

endpackage

// File: rtl/cordic_rr_arb2.sv
// rtl/cordic_rr_arb2.sv - two-way round-robin grant for the shared core
module cordic_rr_arb2
  import cordic_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic rr_ptr,
  output logic ready0,
  output logic ready1
);

  // a lone requester always wins; on contention rr_ptr picks the winner
  assign ready0 = !valid1 || (rr_ptr == 1'b0);
  assign ready1 = !valid0 || (rr_ptr == 1'b1);

endmodule

// File: rtl/cordic_arbiter.sv
// rtl/cordic_arbiter.sv - shares one cordic core between two requesters
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int LATENCY = CORDIC_LATENCY,
  parameter int DW      = CORDIC_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_mode,
  input  logic [DW-1:0] req0_x,
  input  logic [DW-1:0] req0_y,
  input  logic [DW-1:0] req0_z,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_mode,
  input  logic [DW-1:0] req1_x,
  input  logic [DW-1:0] req1_y,
  input  logic [DW-1:0] req1_z,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic [DW-1:0] rsp0_res1,
  output logic [DW-1:0] rsp0_res2,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp1_res1,
  output logic [DW-1:0] rsp1_res2,
  output logic          core_mode,
  output logic [DW-1:0] core_x,
  output logic [DW-1:0] core_y,
  output logic [DW-1:0] core_z,
  input  logic [DW-1:0] core_res1,
  input  logic [DW-1:0] core_res2,
  output logic          busy,
  output logic          grant_id
);

  // the counter reaches zero on the edge where the core result is due
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  cordic_state_e state, state_nx;
  logic [7:0]    cnt;
  logic          rr_ptr;
  logic [DW-1:0] res1_q, res2_q;
  logic          arb_ready0, arb_ready1;
  logic          idle, acc0, acc1, accept, rsp_ack, cnt_done;

  cordic_rr_arb2 u_arb (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .rr_ptr (rr_ptr),
    .ready0 (arb_ready0),
    .ready1 (arb_ready1)
  );

  assign idle       = (state == IDLE);
  assign req0_ready = idle && arb_ready0;
  assign req1_ready = idle && arb_ready1;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign accept     = acc0 || acc1;
  assign cnt_done   = (cnt == 8'd0);
  // only the granted port may retire the response
  assign rsp_ack    = grant_id ? rsp1_ready : rsp0_ready;

  assign busy       = !idle;
  assign rsp0_valid = (state == RESP) && !grant_id;
  assign rsp1_valid = (state == RESP) &&  grant_id;
  assign rsp0_res1  = res1_q;
  assign rsp0_res2  = res2_q;
  assign rsp1_res1  = res1_q;
  assign rsp1_res2  = res2_q;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state: one job in flight, new requests ignored until it retires
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)   state_nx = WAIT;
      WAIT:    if (cnt_done) state_nx = RESP;
      RESP:    if (rsp_ack)  state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  // job datapath: latch operands on accept, count down, capture result, rotate priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= 8'd0;
      rr_ptr    <= 1'b0;
      grant_id  <= 1'b0;
      core_mode <= 1'b0;
      core_x    <= '0;
      core_y    <= '0;
      core_z    <= '0;
      res1_q    <= '0;
      res2_q    <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          grant_id  <= acc1;
          cnt       <= CNT_INIT;
          core_mode <= acc1 ? req1_mode : req0_mode;
          core_x    <= acc1 ? req1_x    : req0_x;
          core_y    <= acc1 ? req1_y    : req0_y;
          core_z    <= acc1 ? req1_z    : req0_z;
        end
        WAIT: begin
          if (cnt_done) begin
            res1_q <= core_res1;
            res2_q <= core_res2;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: if (rsp_ack) rr_ptr <= !grant_id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb/tb_cordic_arbiter.sv - self-checking bench for cordic_arbiter
module tb_cordic_arbiter;

  localparam int LAT = 16;

  typedef struct packed {
    logic        mode;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } op_t;

  typedef struct {
    logic v0;
    logic v1;
    op_t  o0;
    op_t  o1;
    int   stall;
    int   win;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cyc = '0;

  logic req0_valid, req0_ready, req0_mode, req1_valid, req1_ready, req1_mode;
  logic [15:0] req0_x, req0_y, req0_z, req1_x, req1_y, req1_z;
  logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [15:0] rsp0_res1, rsp0_res2, rsp1_res1, rsp1_res2;
  logic core_mode, busy, grant_id;
  logic [15:0] core_x, core_y, core_z, core_res1, core_res2;

  logic b_req0_valid, b_req0_ready, b_req0_mode, b_req1_valid, b_req1_ready, b_req1_mode;
  logic [15:0] b_req0_x, b_req0_y, b_req0_z, b_req1_x, b_req1_y, b_req1_z;
  logic b_rsp0_valid, b_rsp0_ready, b_rsp1_valid, b_rsp1_ready;
  logic [15:0] b_rsp0_res1, b_rsp0_res2, b_rsp1_res1, b_rsp1_res2;
  logic b_core_mode, b_busy, b_grant_id;
  logic [15:0] b_core_x, b_core_y, b_core_z, b_core_res1, b_core_res2;

  int  n_chk = 0;
  int  n_err = 0;
  int  mrr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  // stand-in core: result depends on operands and on the cycle it is sampled in
  function automatic logic [15:0] f_res1(op_t o, logic [15:0] t);
    return (o.mode ? (o.x + o.z) : (o.x - o.y)) ^ t;
  endfunction
  function automatic logic [15:0] f_res2(op_t o, logic [15:0] t);
    return (o.y ^ o.z) + {15'd0, o.mode} + t;
  endfunction
  function automatic op_t mk(logic m, logic [15:0] x, logic [15:0] y, logic [15:0] z);
    op_t o;
    o.mode = m; o.x = x; o.y = y; o.z = z;
    return o;
  endfunction

  assign core_res1   = f_res1(op_t'({core_mode, core_x, core_y, core_z}), cyc);
  assign core_res2   = f_res2(op_t'({core_mode, core_x, core_y, core_z}), cyc);
  assign b_core_res1 = f_res1(op_t'({b_core_mode, b_core_x, b_core_y, b_core_z}), cyc);
  assign b_core_res2 = f_res2(op_t'({b_core_mode, b_core_x, b_core_y, b_core_z}), cyc);

  cordic_arbiter #(.LATENCY(LAT), .DW(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_x(req0_x), .req0_y(req0_y), .req0_z(req0_z),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_x(req1_x), .req1_y(req1_y), .req1_z(req1_z),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res1(rsp0_res1), .rsp0_res2(rsp0_res2),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res1(rsp1_res1), .rsp1_res2(rsp1_res2),
    .core_mode(core_mode), .core_x(core_x), .core_y(core_y), .core_z(core_z),
    .core_res1(core_res1), .core_res2(core_res2), .busy(busy), .grant_id(grant_id)
  );

  cordic_arbiter #(.LATENCY(1), .DW(16)) dut_l1 (
    .clk(clk), .reset(reset),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_mode(b_req0_mode),
    .req0_x(b_req0_x), .req0_y(b_req0_y), .req0_z(b_req0_z),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_mode(b_req1_mode),
    .req1_x(b_req1_x), .req1_y(b_req1_y), .req1_z(b_req1_z),
    .rsp0_valid(b_rsp0_valid), .rsp0_ready(b_rsp0_ready), .rsp0_res1(b_rsp0_res1), .rsp0_res2(b_rsp0_res2),
    .rsp1_valid(b_rsp1_valid), .rsp1_ready(b_rsp1_ready), .rsp1_res1(b_rsp1_res1), .rsp1_res2(b_rsp1_res2),
    .core_mode(b_core_mode), .core_x(b_core_x), .core_y(b_core_y), .core_z(b_core_z),
    .core_res1(b_core_res1), .core_res2(b_core_res2), .busy(b_busy), .grant_id(b_grant_id)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rst(input string t);
    chk({t, "_busy"}, 64'(busy), 64'd0);
    chk({t, "_grant_id"}, 64'(grant_id), 64'd0);
    chk({t, "_core"}, 64'({core_mode, core_x, core_y, core_z}), 64'd0);
    chk({t, "_rsp_valid"}, 64'({rsp0_valid, rsp1_valid}), 64'd0);
    chk({t, "_res"}, 64'({rsp0_res1, rsp0_res2}), 64'd0);
  endtask

  // one job through the shared core; win<0 means the round-robin model picks the winner
  task automatic run_job(input logic v0, input logic v1, input op_t o0, input op_t o1,
                         input int stall, input int exp_win);
    int win, los, edges;
    op_t ow;
    logic [15:0] c0, e1, e2;
    logic wv, lv;
    win = (exp_win >= 0) ? exp_win : ((v0 && v1) ? mrr : (v0 ? 0 : 1));
    los = 1 - win;
    ow  = win ? o1 : o0;
    @(negedge clk);
    req0_valid = v0; {req0_mode, req0_x, req0_y, req0_z} = o0;
    req1_valid = v1; {req1_mode, req1_x, req1_y, req1_z} = o1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    chk("ready_winner", 64'(win ? req1_ready : req0_ready), 64'd1);
    chk("ready_loser", 64'(win ? req0_ready : req1_ready), 64'((v0 && v1) ? 0 : (mrr == los)));
    c0 = cyc;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("core_ops", 64'({core_mode, core_x, core_y, core_z}), 64'(ow));
    chk("grant_id", 64'(grant_id), 64'(win));
    chk("busy_wait", 64'({busy, req0_ready, req1_ready}), 64'b100);
    while (!(rsp0_valid || rsp1_valid) && edges < 300) begin
      @(posedge clk); edges++; @(negedge clk);
    end
    chk("rsp_latency", 64'(edges), 64'(LAT + 1));
    e1 = f_res1(ow, c0 + 16'(LAT));
    e2 = f_res2(ow, c0 + 16'(LAT));
    wv = win ? rsp1_valid : rsp0_valid;
    lv = win ? rsp0_valid : rsp1_valid;
    chk("rsp_valid", 64'({wv, lv}), 64'b10);
    chk("rsp_res", 64'(win ? {rsp1_res1, rsp1_res2} : {rsp0_res1, rsp0_res2}), 64'({e1, e2}));
    if (stall > 0) begin
      if (win) rsp1_ready = 1'b0; else rsp0_ready = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); @(negedge clk);
      wv = win ? rsp1_valid : rsp0_valid;
      chk("stall_valid_busy", 64'({wv, busy, req0_ready, req1_ready}), 64'b1100);
      chk("stall_res", 64'(win ? {rsp1_res1, rsp1_res2} : {rsp0_res1, rsp0_res2}), 64'({e1, e2}));
    end
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("retire", 64'({busy, rsp0_valid, rsp1_valid}), 64'd0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    mrr = los;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    op_t  oa, ob, oc, o0, o1;
    int   seen, n_acc, v, edges;
    int   acc_t[8];
    logic [15:0] c0;

    req0_valid = 0; req0_mode = 0; req0_x = 0; req0_y = 0; req0_z = 0;
    req1_valid = 0; req1_mode = 0; req1_x = 0; req1_y = 0; req1_z = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    b_req0_valid = 0; b_req0_mode = 0; b_req0_x = 0; b_req0_y = 0; b_req0_z = 0;
    b_req1_valid = 0; b_req1_mode = 0; b_req1_x = 0; b_req1_y = 0; b_req1_z = 0;
    b_rsp0_ready = 0; b_rsp1_ready = 0;

    oa = mk(1'b0, 16'h1234, 16'h0456, 16'h8001);
    ob = mk(1'b1, 16'h7FFF, 16'hFFFF, 16'h0001);
    oc = mk(1'b0, 16'hC0DE, 16'h0BAD, 16'hFACE);
    tbl[0] = '{1'b1, 1'b1, oa, ob, 0, 0};
    tbl[1] = '{1'b1, 1'b1, oa, ob, 0, 1};
    tbl[2] = '{1'b1, 1'b1, oc, oa, 2, 0};
    tbl[3] = '{1'b1, 1'b0, mk(1'b1, 16'h1A60, 16'h0E00, 16'h0200), ob, 0, 0};
    tbl[4] = '{1'b0, 1'b1, oa, oc, 10, 1};
    tbl[5] = '{1'b0, 1'b1, ob, ob, 0, 1};
    tbl[6] = '{1'b1, 1'b0, oc, oa, 1, 0};

    repeat (2) @(negedge clk);
    chk_rst("por");
    @(posedge clk); #2 reset = 1'b1;

    foreach (tbl[i]) run_job(tbl[i].v0, tbl[i].v1, tbl[i].o0, tbl[i].o1, tbl[i].stall, tbl[i].win);

    // reset in the middle of a req1 job, with the counter at 7
    @(negedge clk);
    req1_valid = 1'b1; {req1_mode, req1_x, req1_y, req1_z} = oc;
    @(posedge clk); @(negedge clk);
    req1_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_job", 64'({busy, grant_id}), 64'b11);
    reset = 1'b0;
    #1;
    chk_rst("mid_reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    mrr = 0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid || busy) seen++;
    end
    chk("no_rsp_after_reset", 64'(seen), 64'd0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    run_job(1'b1, 1'b1, oa, oc, 0, 0);

    for (int i = 0; i < 24; i++) begin
      v  = int'($urandom_range(1, 3));
      o0 = mk(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      o1 = mk(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      run_job(v[0], v[1], o0, o1, int'($urandom_range(0, 3)), -1);
    end

    // streaming on req1 with the response side always ready
    @(negedge clk);
    req1_valid = 1'b1; {req1_mode, req1_x, req1_y, req1_z} = ob;
    rsp1_ready = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (req1_ready && n_acc < 8) begin
        acc_t[n_acc] = int'(cyc);
        n_acc++;
      end
    end
    req1_valid = 1'b0;
    chk("stream_accepts", 64'(n_acc >= 4), 64'd1);
    for (int k = 1; k < n_acc && k < 5; k++) chk("stream_spacing", 64'(acc_t[k] - acc_t[k-1]), 64'(LAT + 2));
    repeat (25) @(negedge clk);
    chk("stream_drained", 64'(busy), 64'd0);
    rsp1_ready = 1'b0;

    // LATENCY=1 build
    @(negedge clk);
    b_req0_valid = 1'b1;
    {b_req0_mode, b_req0_x, b_req0_y, b_req0_z} = mk(1'b0, 16'hB994, 16'h0321, 16'h801F);
    #1;
    chk("l1_ready", 64'(b_req0_ready), 64'd1);
    c0 = cyc;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    b_req0_valid = 1'b0;
    while (!b_rsp0_valid && edges < 20) begin
      @(posedge clk); edges++; @(negedge clk);
    end
    chk("l1_latency", 64'(edges), 64'd2);
    chk("l1_res", 64'({b_rsp0_res1, b_rsp0_res2}),
        64'({f_res1(mk(1'b0, 16'hB994, 16'h0321, 16'h801F), c0 + 16'd1),
             f_res2(mk(1'b0, 16'hB994, 16'h0321, 16'h801F), c0 + 16'd1)}));
    b_rsp0_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("l1_retire", 64'({b_busy, b_rsp0_valid}), 64'd0);
    b_rsp0_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
